dm_port_arbiter: RTL
====================

# dm_port_arbiter

Shares the single data-memory port between the pipeline's MEM stage and a debug/dump requester. It allows inspection or preload of memory while the CPU runs, without a second memory port. The MEM stage has priority. A starvation guard forces a one-cycle pipeline stall so a waiting debug request is served within a bounded time. The block sits between the MEM stage, the data memory and the debug requester inside the CPU top.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on all address ports
- DATA_W, 32, data width
- STARVE_MAX, 8, consecutive denied debug cycles before a forced grant; legal range 1..255

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- cpu_mem_read_i  in  1  MEM-stage load this cycle
- cpu_mem_write_i  in  1  MEM-stage store this cycle
- cpu_addr_i  in  ADDR_W  MEM-stage address
- cpu_wdata_i  in  DATA_W  MEM-stage store data
- cpu_rdata_o  out  DATA_W  load data; combinational passthrough of dm_rdata_i
- cpu_stall_o  out  1  freeze PC/IF/ID/EX/MEM and their pipeline registers this cycle
- dbg_req_i  in  1  debug access request; held with addr/data until granted
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  ADDR_W  debug address
- dbg_wdata_i  in  DATA_W  debug write data
- dbg_gnt_o  out  1  combinational; access is performed this cycle
- dbg_rvalid_o  out  1  registered; read data valid, one cycle after a read grant
- dbg_rdata_o  out  DATA_W  registered read data
- dm_addr_o  out  ADDR_W  memory address
- dm_wdata_o  out  DATA_W  memory write data
- dm_read_o  out  1  memory read strobe
- dm_write_o  out  1  memory write strobe (memory writes on the clock edge)
- dm_rdata_i  in  DATA_W  memory combinational read data

## Operation
- cpu_act = cpu_mem_read_i | cpu_mem_write_i.
- FSM states:
  - IDLE: grant the debug requester iff dbg_req_i & !cpu_act. Otherwise the CPU drives the memory port.
  - FORCE: if dbg_req_i, assert cpu_stall_o and grant the debug requester. The CPU strobes are suppressed regardless of dbg_req_i. Always return to IDLE next cycle.
- starve_cnt (8 bit):
  - Increments in IDLE when dbg_req_i & cpu_act.
  - Clears on any grant, on !dbg_req_i, and in FORCE.
  - When the post-increment value equals STARVE_MAX, the next state is FORCE.
- Mux: when dbg_gnt_o is high, dm_* carry the debug address, data and strobes (dm_read_o = !dbg_we_i, dm_write_o = dbg_we_i). Otherwise dm_* carry the CPU signals.
- When neither side accesses, the strobes are 0 and address/data are 0.
- On a debug read grant, dbg_rdata_o <= dm_rdata_i and dbg_rvalid_o <= 1 for one cycle. Otherwise dbg_rvalid_o <= 0 and dbg_rdata_o holds.
- Never assert both CPU and debug strobes in the same cycle.
- Reset values: state IDLE, starve_cnt 0, dbg_rvalid_o 0, dbg_rdata_o 0. Combinational outputs follow from reset state: cpu_stall_o 0, dbg_gnt_o 0 unless IDLE-grant conditions hold.
- Reset mid-operation: a pending rvalid is dropped, and FORCE is abandoned with no stall in the reset cycle.

## Timing
- Debug grant latency:
  - 0 cycles if the port is free.
  - Otherwise at most STARVE_MAX+1 cycles after dbg_req_i rises.
- Read data appears 1 cycle after grant.
- cpu_stall_o lasts exactly 1 cycle per forced grant.
- Back-to-back debug requests are granted on consecutive free cycles.
- Simultaneous CPU access and debug request in IDLE: the CPU wins.
- In FORCE the debug requester wins.

## Configuration
- DM_ARB_STARVE_GUARD_EN defined: FORCE state and starve_cnt are present as described.
- Not defined:
  - FSM is IDLE only.
  - cpu_stall_o is tied 0.
  - Debug is granted only on CPU-idle cycles, with no latency bound.

## Test plan
- Reset held 2 cycles with random inputs -> cpu_stall_o=0, dbg_rvalid_o=0, dbg_rdata_o=0, no dm_write_o.
- CPU idle, debug write addr 12 data 0x55 then debug read addr 12 -> gnt in the same cycle each; the next cycle gives dbg_rvalid_o=1, dbg_rdata_o=0x55.
- CPU store addr 4 data 7 concurrent with debug read addr 4, free cycle next -> CPU write occurs first; the debug read returns 7 one cycle after its grant.
- STARVE_MAX=3, CPU loads every cycle, dbg_req_i held -> cycles 0-2 denied; cycle 3 gives cpu_stall_o=1 and dbg_gnt_o=1; cycle 4 gives the CPU the port and stall=0.
- Guard disabled, same stimulus for 50 cycles -> dbg_gnt_o never asserts, cpu_stall_o always 0.
- rst_i asserted in the FORCE cycle -> no stall and no grant-driven write; the next cycle is IDLE with starve_cnt=0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one data-memory port between the MEM stage (priority) and a debug requester.
// Define DM_ARB_STARVE_GUARD_EN to add the FORCE state that stalls the CPU for one cycle to serve a starved debug request.
module dm_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_mem_read_i,
   input  logic              cpu_mem_write_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic [ADDR_W-1:0] dm_addr_o,
   output logic [DATA_W-1:0] dm_wdata_o,
   output logic              dm_read_o,
   output logic              dm_write_o,
   input  logic [DATA_W-1:0] dm_rdata_i
);
   logic              w_cpu_act, w_cpu_en, w_cpu_go, w_gnt, w_stall;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
      $error("STARVE_MAX must be within 1..255");
   end
   assign w_cpu_act = cpu_mem_read_i | cpu_mem_write_i;
`ifdef DM_ARB_STARVE_GUARD_EN
   typedef enum logic {S_IDLE, S_FORCE} state_t;
   state_t     r_state, w_state_nxt;
   logic [7:0] r_starve, w_starve_nxt;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
      end
   end
   // The port stays quiet while reset is asserted, so an interrupted FORCE neither stalls nor writes.
   always_comb begin
      w_state_nxt  = S_IDLE;
      w_starve_nxt = '0;
      w_gnt        = 1'b0;
      w_stall      = 1'b0;
      w_cpu_en     = !rst_i;
      if (r_state == S_FORCE) begin
         w_gnt    = dbg_req_i & !rst_i;
         w_stall  = w_gnt;
         w_cpu_en = 1'b0;
      end else begin
         w_gnt        = dbg_req_i & !w_cpu_act & !rst_i;
         w_starve_nxt = (dbg_req_i & w_cpu_act) ? r_starve + 8'd1 : 8'd0;
         w_state_nxt  = (w_starve_nxt == 8'(STARVE_MAX)) ? S_FORCE : S_IDLE;
      end
   end
`else
   assign w_gnt    = dbg_req_i & !w_cpu_act & !rst_i;
   assign w_stall  = 1'b0;
   assign w_cpu_en = !rst_i;
`endif
   assign w_cpu_go     = w_cpu_en & w_cpu_act;
   assign dm_addr_o    = w_gnt ? dbg_addr_i  : w_cpu_go ? cpu_addr_i  : '0;
   assign dm_wdata_o   = w_gnt ? dbg_wdata_i : w_cpu_go ? cpu_wdata_i : '0;
   assign dm_read_o    = w_gnt ? !dbg_we_i : w_cpu_en & cpu_mem_read_i;
   assign dm_write_o   = w_gnt ?  dbg_we_i : w_cpu_en & cpu_mem_write_i;
   assign dbg_gnt_o    = w_gnt;
   assign cpu_stall_o  = w_stall;
   assign cpu_rdata_o  = dm_rdata_i;
   assign dbg_rvalid_o = r_rvalid;
   assign dbg_rdata_o  = r_rdata;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_gnt & !dbg_we_i;
         if (w_gnt & !dbg_we_i) r_rdata <= dm_rdata_i;
      end
   end
endmodule
